// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared encodings for the I2C transaction sequencer: element conditions,
// sequencer states and txd element field layout.
package tqvp_dlmiles_i2c_pkg;

  typedef enum logic [1:0] {
    COND_NONE    = 2'b00,
    COND_START   = 2'b01,
    COND_RESTART = 2'b10,
    COND_STOP    = 2'b11
  } cond_e;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    REG,
    RADDR,
    WDATA,
    RDATA,
    WAIT_ACK,
    WAIT_RX,
    STOP
  } state_e;

  localparam int unsigned COND_MSB = 10;
  localparam int unsigned COND_LSB = 9;
  localparam int unsigned DIR_BIT  = 8;

  localparam logic DIR_TXD = 1'b0;
  localparam logic DIR_RXD = 1'b1;

  function automatic logic [10:0] make_elem(cond_e c, logic dir, logic [7:0] d);
    logic [10:0] e;
    e                    = '0;
    e[COND_MSB:COND_LSB] = c;
    e[DIR_BIT]           = dir;
    e[7:0]               = d;
    return e;
  endfunction

endpackage

// File: rtl/tqvp_dlmiles_i2c_seq_wdog.sv
// Watchdog for the I2C sequencer: counts enabled cycles, saturates at
// all-ones and raises expire while enabled at that value.
module tqvp_dlmiles_i2c_seq_wdog #(
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign expire = en && (cnt_q == '1);

endmodule

// File: rtl/tqvp_dlmiles_i2c_seq.sv
// I2C transaction sequencer: expands one command into START/addr/reg/data/STOP
// elements for the bit-level FSM. Optional watchdog: define I2C_SEQ_TIMEOUT_EN.
module tqvp_dlmiles_i2c_seq
  import tqvp_dlmiles_i2c_pkg::*;
#(
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_rnw_i,
  input  logic [6:0]       cmd_dev_i,
  input  logic             cmd_reg_en_i,
  input  logic [7:0]       cmd_reg_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic [10:0]      txd_o,
  output logic             txd_valid_o,
  input  logic             txd_ready_i,
  input  logic             acknack_i,
  input  logic             acknack_valid_i,
  input  logic [7:0]       rxd_data_i,
  input  logic             rxd_valid_i,
  input  logic             fsm_error_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_nack_o,
  output logic             err_bus_o,
  output logic             err_timeout_o
);

  localparam logic [10:0] STOP_ELEM = 11'h600;

  state_e           state_q, state_d, ret_q, ret_d;
  logic             rnw_q, rnw_d, reg_en_q, reg_en_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d, rd_data_q, rd_data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [10:0]      txd_q, txd_d;
  logic             txd_valid_q, txd_valid_d, rd_valid_q, rd_valid_d, done_q, done_d;
  logic             err_nack_q, err_nack_d, err_bus_q, err_bus_d, err_to_q, err_to_d;
  logic             txd_fire, wdog_expire;

  assign txd_fire = txd_valid_q && txd_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      rnw_q       <= 1'b0;
      reg_en_q    <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      cnt_q       <= '0;
      txd_q       <= '0;
      txd_valid_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_nack_q  <= 1'b0;
      err_bus_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      rnw_q       <= rnw_d;
      reg_en_q    <= reg_en_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      cnt_q       <= cnt_d;
      txd_q       <= txd_d;
      txd_valid_q <= txd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_nack_q  <= err_nack_d;
      err_bus_q   <= err_bus_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    rnw_d       = rnw_q;
    reg_en_d    = reg_en_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    cnt_d       = cnt_q;
    txd_d       = txd_q;
    txd_valid_d = txd_valid_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_nack_d  = err_nack_q;
    err_bus_d   = err_bus_q;
    err_to_d    = err_to_q;

    unique case (state_q)
      IDLE: if (cmd_valid_i) begin
        rnw_d       = cmd_rnw_i;
        reg_en_d    = cmd_reg_en_i;
        dev_d       = cmd_dev_i;
        reg_d       = cmd_reg_i;
        cnt_d       = cmd_len_i;
        err_nack_d  = 1'b0;
        err_bus_d   = 1'b0;
        err_to_d    = 1'b0;
        txd_d       = make_elem(COND_START, DIR_TXD, {cmd_dev_i, cmd_rnw_i & ~cmd_reg_en_i});
        txd_valid_d = 1'b1;
        state_d     = ADDR;
      end
      ADDR, REG, RADDR: if (txd_fire) begin
        txd_valid_d = 1'b0;
        ret_d       = state_q;
        state_d     = WAIT_ACK;
      end
      WDATA: begin
        if (!txd_valid_q) begin
          if (wr_valid_i) begin
            txd_d       = make_elem(COND_NONE, DIR_TXD, wr_data_i);
            txd_valid_d = 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
          end
        end else if (txd_ready_i) begin
          txd_valid_d = 1'b0;
          ret_d       = WDATA;
          state_d     = WAIT_ACK;
        end
      end
      RDATA: if (txd_fire) begin
        txd_valid_d = 1'b0;
        state_d     = WAIT_RX;
      end
      WAIT_ACK: if (acknack_valid_i) begin
        txd_valid_d = 1'b1;
        // Next element: register byte, restart, data phase or STOP.
        if (acknack_i) begin
          err_nack_d = 1'b1;
          txd_d      = STOP_ELEM;
          state_d    = STOP;
        end else if (ret_q == ADDR && reg_en_q) begin
          txd_d   = make_elem(COND_NONE, DIR_TXD, reg_q);
          state_d = REG;
        end else if (ret_q == REG && rnw_q) begin
          txd_d   = make_elem(COND_RESTART, DIR_TXD, {dev_q, 1'b1});
          state_d = RADDR;
        end else if (cnt_q == '0) begin
          txd_d   = STOP_ELEM;
          state_d = STOP;
        end else if (rnw_q) begin
          txd_d   = make_elem(COND_NONE, DIR_RXD, {7'b0, cnt_q == LEN_W'(1)});
          state_d = RDATA;
        end else begin
          txd_valid_d = 1'b0;
          state_d     = WDATA;
        end
      end
      WAIT_RX: if (rxd_valid_i) begin
        rd_data_d   = rxd_data_i;
        rd_valid_d  = 1'b1;
        txd_valid_d = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q <= LEN_W'(1)) begin
          txd_d   = STOP_ELEM;
          state_d = STOP;
        end else begin
          txd_d   = make_elem(COND_NONE, DIR_RXD, {7'b0, cnt_q == LEN_W'(2)});
          state_d = RDATA;
        end
      end
      STOP: if (txd_fire) begin
        txd_valid_d = 1'b0;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (fsm_error_i) begin
        err_bus_d   = 1'b1;
        txd_valid_d = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        state_d     = IDLE;
      end else if (wdog_expire && !(state_q == WAIT_ACK && acknack_valid_i)
                   && !(state_q == WAIT_RX && rxd_valid_i)) begin
        err_to_d    = 1'b1;
        txd_valid_d = 1'b0;
        state_d     = IDLE;
      end
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic wdog_en;
  assign wdog_en = (state_q == WAIT_ACK) || (state_q == WAIT_RX) || (txd_valid_q && !txd_ready_i);

  tqvp_dlmiles_i2c_seq_wdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_d != state_q),
    .en    (wdog_en),
    .expire(wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign wr_ready_o    = (state_q == WDATA) && !txd_valid_q;
  assign txd_o         = txd_q;
  assign txd_valid_o   = txd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign done_o        = done_q;
  assign err_nack_o    = err_nack_q;
  assign err_bus_o     = err_bus_q;
  assign err_timeout_o = err_to_q;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_seq.sv
// Directed self-checking bench for tqvp_dlmiles_i2c_seq; the timeout scenario
// runs only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_tqvp_dlmiles_i2c_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_rnw_i, cmd_reg_en_i;
  logic [6:0]  cmd_dev_i;
  logic [7:0]  cmd_reg_i;
  logic [3:0]  cmd_len_i;
  logic [7:0]  wr_data_i;
  logic        wr_valid_i, wr_ready_o;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic [10:0] txd_o;
  logic        txd_valid_o, txd_ready_i;
  logic        acknack_i, acknack_valid_i;
  logic [7:0]  rxd_data_i;
  logic        rxd_valid_i, fsm_error_i;
  logic        busy_o, done_o, err_nack_o, err_bus_o, err_timeout_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tqvp_dlmiles_i2c_seq #(
    .LEN_W    (4),
    .TIMEOUT_W(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_rnw_i      (cmd_rnw_i),
    .cmd_dev_i      (cmd_dev_i),
    .cmd_reg_en_i   (cmd_reg_en_i),
    .cmd_reg_i      (cmd_reg_i),
    .cmd_len_i      (cmd_len_i),
    .wr_data_i      (wr_data_i),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .txd_o          (txd_o),
    .txd_valid_o    (txd_valid_o),
    .txd_ready_i    (txd_ready_i),
    .acknack_i      (acknack_i),
    .acknack_valid_i(acknack_valid_i),
    .rxd_data_i     (rxd_data_i),
    .rxd_valid_i    (rxd_valid_i),
    .fsm_error_i    (fsm_error_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_nack_o     (err_nack_o),
    .err_bus_o      (err_bus_o),
    .err_timeout_o  (err_timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic rnw, input logic [6:0] dev, input logic ren,
                           input logic [7:0] rg, input logic [3:0] len);
    cmd_valid_i = 1'b1; cmd_rnw_i = rnw; cmd_dev_i = dev;
    cmd_reg_en_i = ren; cmd_reg_i = rg; cmd_len_i = len;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  // Waits (bounded) for an element, accepts it, returns one cycle after acceptance.
  task automatic get_elem(output logic [10:0] e, output bit ok);
    ok = 1'b0;
    e  = 'x;
    for (int i = 0; i < 50; i++) begin
      if (txd_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      e = txd_o;
      txd_ready_i = 1'b1;
      tick();
      txd_ready_i = 1'b0;
    end
  endtask

  task automatic ack(input logic nack);
    acknack_valid_i = 1'b1; acknack_i = nack;
    tick();
    acknack_valid_i = 1'b0; acknack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] got;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    got = {txd_valid_o, txd_o, rd_valid_o, rd_data_o, done_o, err_nack_o, err_bus_o,
           err_timeout_o, busy_o, wr_ready_o, cmd_ready_o};
    compared++;
    if (got !== 28'h0000001) begin
      mismatched++; $display("FAIL reset_state: got %h want %h", got, 28'h0000001);
    end
  endtask

  task automatic test_write();
    logic [10:0] e;
    bit ok;
    logic [10:0] exp_data [2] = '{11'h0AA, 11'h055};
    logic [7:0]  wbytes   [2] = '{8'hAA, 8'h55};
    issue_cmd(1'b0, 7'h50, 1'b1, 8'h10, 4'd2);
    compared++;
    if ({txd_valid_o, txd_o} !== {1'b1, 11'h2A0}) begin
      mismatched++; $display("FAIL wr_start_latency: got %h want %h", {txd_valid_o, txd_o}, {1'b1, 11'h2A0});
    end
    repeat (3) tick();
    compared++;
    if ({txd_valid_o, txd_o} !== {1'b1, 11'h2A0}) begin
      mismatched++; $display("FAIL wr_stall_stable: got %h want %h", {txd_valid_o, txd_o}, {1'b1, 11'h2A0});
    end
    get_elem(e, ok);
    ack(1'b0);
    get_elem(e, ok);
    compared++;
    if (!ok || e !== 11'h010) begin
      mismatched++; $display("FAIL wr_reg_elem: got %h want %h", e, 11'h010);
    end
    ack(1'b0);
    compared++;
    if (wr_ready_o !== 1'b1) begin
      mismatched++; $display("FAIL wr_ready: got %b want 1", wr_ready_o);
    end
    for (int i = 0; i < 2; i++) begin
      wr_data_i = wbytes[i]; wr_valid_i = 1'b1;
      get_elem(e, ok);
      wr_valid_i = 1'b0;
      compared++;
      if (!ok || e !== exp_data[i]) begin
        mismatched++; $display("FAIL wr_data_elem%0d: got %h want %h", i, e, exp_data[i]);
      end
      ack(1'b0);
    end
    get_elem(e, ok);
    compared++;
    if (!ok || e !== 11'h600) begin
      mismatched++; $display("FAIL wr_stop_elem: got %h want %h", e, 11'h600);
    end
    compared++;
    if ({done_o, busy_o, err_nack_o, err_bus_o, err_timeout_o} !== 5'b10000) begin
      mismatched++; $display("FAIL wr_done: got %b want %b", {done_o, busy_o, err_nack_o, err_bus_o, err_timeout_o}, 5'b10000);
    end
    tick();
    compared++;
    if (done_o !== 1'b0) begin
      mismatched++; $display("FAIL wr_done_pulse: got %b want 0", done_o);
    end
  endtask

  task automatic test_read();
    logic [10:0] e;
    bit ok;
    logic [10:0] hdr [3] = '{11'h2A0, 11'h000, 11'h4A1};
    logic [10:0] rxe [3] = '{11'h100, 11'h100, 11'h101};
    logic [7:0]  rxb [3] = '{8'h11, 8'h22, 8'h33};
    issue_cmd(1'b1, 7'h50, 1'b1, 8'h00, 4'd3);
    for (int i = 0; i < 3; i++) begin
      get_elem(e, ok);
      compared++;
      if (!ok || e !== hdr[i]) begin
        mismatched++; $display("FAIL rd_hdr%0d: got %h want %h", i, e, hdr[i]);
      end
      ack(1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      get_elem(e, ok);
      compared++;
      if (!ok || e !== rxe[i]) begin
        mismatched++; $display("FAIL rd_rx_elem%0d: got %h want %h", i, e, rxe[i]);
      end
      rxd_data_i = rxb[i]; rxd_valid_i = 1'b1;
      tick();
      rxd_valid_i = 1'b0;
      compared++;
      if ({rd_valid_o, rd_data_o} !== {1'b1, rxb[i]}) begin
        mismatched++; $display("FAIL rd_byte%0d: got %h want %h", i, {rd_valid_o, rd_data_o}, {1'b1, rxb[i]});
      end
    end
    tick();
    compared++;
    if (rd_valid_o !== 1'b0) begin
      mismatched++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid_o);
    end
    get_elem(e, ok);
    compared++;
    if (!ok || e !== 11'h600 || done_o !== 1'b1) begin
      mismatched++; $display("FAIL rd_stop_done: got %h/%b want %h/1", e, done_o, 11'h600);
    end
  endtask

  task automatic test_probe_nack();
    logic [10:0] e;
    bit ok;
    issue_cmd(1'b0, 7'h3C, 1'b0, 8'h00, 4'd0);
    get_elem(e, ok);
    compared++;
    if (!ok || e !== 11'h278) begin
      mismatched++; $display("FAIL probe_addr: got %h want %h", e, 11'h278);
    end
    ack(1'b1);
    get_elem(e, ok);
    compared++;
    if (!ok || {e, done_o, busy_o, err_nack_o} !== {11'h600, 3'b101}) begin
      mismatched++; $display("FAIL probe_nack_stop: got %h want %h", {e, done_o, busy_o, err_nack_o}, {11'h600, 3'b101});
    end
  endtask

  task automatic test_bus_error();
    logic [10:0] e;
    bit ok;
    logic seen;
    issue_cmd(1'b0, 7'h50, 1'b1, 8'h10, 4'd1);
    compared++;
    if (err_nack_o !== 1'b0) begin
      mismatched++; $display("FAIL err_clear_on_cmd: got %b want 0", err_nack_o);
    end
    get_elem(e, ok);
    ack(1'b0);
    get_elem(e, ok);
    fsm_error_i = 1'b1; acknack_valid_i = 1'b1; acknack_i = 1'b0;
    tick();
    fsm_error_i = 1'b0; acknack_valid_i = 1'b0;
    compared++;
    if ({busy_o, cmd_ready_o, err_bus_o, txd_valid_o, done_o} !== 5'b01100) begin
      mismatched++; $display("FAIL bus_err_abort: got %b want %b", {busy_o, cmd_ready_o, err_bus_o, txd_valid_o, done_o}, 5'b01100);
    end
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen |= txd_valid_o | done_o;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++; $display("FAIL bus_err_no_stop: got %b want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e;
    bit ok;
    logic [27:0] got;
    issue_cmd(1'b0, 7'h50, 1'b0, 8'h00, 4'd2);
    get_elem(e, ok);
    ack(1'b0);
    wr_data_i = 8'hAA; wr_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    compared++;
    if ({txd_valid_o, txd_o} !== {1'b1, 11'h0AA}) begin
      mismatched++; $display("FAIL mid_wdata_elem: got %h want %h", {txd_valid_o, txd_o}, {1'b1, 11'h0AA});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {txd_valid_o, txd_o, rd_valid_o, rd_data_o, done_o, err_nack_o, err_bus_o,
           err_timeout_o, busy_o, wr_ready_o, cmd_ready_o};
    compared++;
    if (got !== 28'h0000001) begin
      mismatched++; $display("FAIL mid_reset_state: got %h want %h", got, 28'h0000001);
    end
    issue_cmd(1'b1, 7'h3C, 1'b0, 8'h00, 4'd0);
    compared++;
    if ({txd_valid_o, txd_o} !== {1'b1, 11'h279}) begin
      mismatched++; $display("FAIL post_reset_cmd: got %h want %h", {txd_valid_o, txd_o}, {1'b1, 11'h279});
    end
    get_elem(e, ok);
    ack(1'b0);
    get_elem(e, ok);
    compared++;
    if (!ok || {e, done_o} !== {11'h600, 1'b1}) begin
      mismatched++; $display("FAIL post_reset_done: got %h want %h", {e, done_o}, {11'h600, 1'b1});
    end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    issue_cmd(1'b0, 7'h22, 1'b0, 8'h00, 4'd0);
    repeat (15) tick();
    compared++;
    if ({err_timeout_o, txd_valid_o} !== 2'b01) begin
      mismatched++; $display("FAIL timeout_early: got %b want 01", {err_timeout_o, txd_valid_o});
    end
    tick();
    compared++;
    if ({err_timeout_o, txd_valid_o, cmd_ready_o, done_o} !== 4'b1010) begin
      mismatched++; $display("FAIL timeout_abort: got %b want 1010", {err_timeout_o, txd_valid_o, cmd_ready_o, done_o});
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_rnw_i = 1'b0; cmd_dev_i = '0; cmd_reg_en_i = 1'b0;
    cmd_reg_i = '0; cmd_len_i = '0; wr_data_i = '0; wr_valid_i = 1'b0;
    txd_ready_i = 1'b0; acknack_i = 1'b0; acknack_valid_i = 1'b0;
    rxd_data_i = '0; rxd_valid_i = 1'b0; fsm_error_i = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_probe_nack();
    test_bus_error();
    test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tqvp_dlmiles_i2c_seq.md
# tqvp_dlmiles_i2c_seq

Transaction sequencer for the I2C peripheral. It turns one high-level command (device address, optional register byte, direction, byte count) into the ordered stream of byte elements consumed by the I2C bit-level FSM: START/RESTART, address, data and STOP. It tracks ACK/NACK and received bytes, and aborts cleanly on NACK, bus error or timeout. It sits between the CPU-facing FIFOs and `tqvp_dlmiles_i2c_fsm`, so the CPU does not have to hand-build condition and ACK framing.

## Interface
Parameters:
- `LEN_W`, default 4: width of the byte-count field. A transaction carries at most 2^LEN_W−1 data bytes.
- `TIMEOUT_W`, default 12: width of the watchdog counter. Used only with `I2C_SEQ_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high. The block has one clock.
- `cmd_valid_i` in 1; `cmd_ready_o` out 1: command handshake.
- `cmd_rnw_i` in 1: 1 = read, 0 = write.
- `cmd_dev_i` in 7: 7-bit device address.
- `cmd_reg_en_i` in 1: send a register byte. `cmd_reg_i` in 8: that register byte.
- `cmd_len_i` in LEN_W: number of data bytes. 0 is an address-only probe.
- `wr_data_i` in 8, `wr_valid_i` in 1, `wr_ready_o` out 1: write-data stream.
- `rd_data_o` out 8, `rd_valid_o` out 1: received byte; `rd_valid_o` is a 1-cycle strobe.
- `txd_o` out 11, `txd_valid_o` out 1, `txd_ready_i` in 1: element stream to the FSM. Fields:
  - [10:9] condition: 00 none, 01 START, 10 RESTART, 11 STOP.
  - [8] direction: 1 = receive.
  - [7:0] data. For receive elements, bit 0 is the ACK bit to send (1 = NACK).
- `acknack_i` in 1 (1 = NACK), `acknack_valid_i` in 1: ACK/NACK result of a transmitted byte.
- `rxd_data_i` in 8, `rxd_valid_i` in 1: received byte from the FSM.
- `fsm_error_i` in 1: FSM error strobe.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: 1-cycle strobe.
- `err_nack_o`, `err_bus_o`, `err_timeout_o` out 1 each: sticky error flags.

## Operation
- States: IDLE, ADDR, REG, RADDR, WDATA, RDATA, WAIT_ACK, WAIT_RX, STOP.
- `cmd_ready_o` = (state == IDLE). On acceptance:
  - All command fields are latched.
  - All sticky error flags are cleared.
  - The remaining-byte counter is loaded with `cmd_len_i`.
- Write sequence:
  - {START, dev<<1|0}
  - {none, reg}, only if `cmd_reg_en_i`
  - `len` × {none, wr_data}
  - {STOP}
- Read sequence with a register byte:
  - {START, dev<<1|0}
  - {none, reg}
  - {RESTART, dev<<1|1}
  - `len` × receive element
  - {STOP}
- Read sequence without a register byte: {START, dev<<1|1}, then `len` × receive element, then {STOP}.
- Receive element ACK bit: data[0] = 1 (NACK) on the last byte, 0 otherwise.
- Every transmit element is followed by WAIT_ACK.
  - ACK: advance to the next element.
  - NACK: set `err_nack_o`, go to STOP.
- Every receive element is followed by WAIT_RX. On `rxd_valid_i`, register the byte into `rd_data_o` and decrement the counter.
- Write data path:
  - In WDATA, `wr_ready_o` = !`txd_valid_o`.
  - The accepted byte becomes the registered `txd_o` element the next cycle.
- `fsm_error_i` in any non-IDLE state: set `err_bus_o`, drop `txd_valid_o`, go to IDLE with no STOP and no `done_o`.
- `done_o` pulses once after the STOP element is accepted, including after a NACK abort.
- Simultaneous events:
  - `fsm_error_i` takes priority over `acknack_valid_i` and `rxd_valid_i`.
  - `acknack_valid_i` / `rxd_valid_i` take priority over a timeout expiry in the same cycle.
  - `cmd_valid_i` while busy is ignored.
  - Counter wrap is impossible, because the decrement happens only while the counter is nonzero.

## Timing
- Reset values:
  - state IDLE, `txd_valid_o` 0, `txd_o` 0.
  - `rd_valid_o` 0, `rd_data_o` 0, `done_o` 0.
  - all `err_*` 0, `busy_o` 0, `wr_ready_o` 0.
  - `cmd_ready_o` 1.
- Reset mid-transaction forces these values on the next edge. No STOP is emitted.
- Command accepted at edge N: `txd_valid_o` is high from cycle N+1 with the START element.
- `txd_o` is stable while `txd_valid_o && !txd_ready_i`. The next element is presented no earlier than 1 cycle after acceptance.
- `rd_valid_o` is high exactly in the cycle after `rxd_valid_i`.
- `done_o` is high in the cycle after the STOP acceptance edge. `busy_o` is low in that same cycle.

## Configuration
- Macro: `I2C_SEQ_TIMEOUT_EN`.
- Defined:
  - A TIMEOUT_W-bit watchdog counts cycles spent in WAIT_ACK, WAIT_RX, or with `txd_valid_o && !txd_ready_i`.
  - The counter resets on every state change.
  - When it reaches all-ones: set `err_timeout_o`, drop `txd_valid_o`, go to IDLE with no `done_o`.
- Not defined: no counter is built, `err_timeout_o` is tied to 0, and the block waits indefinitely.

## Structure
- `tqvp_dlmiles_i2c_pkg` holds:
  - the condition encodings (COND_NONE/START/RESTART/STOP);
  - the state enum;
  - the `txd_o` field offsets (COND_MSB/LSB, DIR_BIT);
  - the DIR_TXD/DIR_RXD constants.
- Sub-module `tqvp_dlmiles_i2c_seq_wdog`: the watchdog counter with clear/enable inputs and an expiry strobe output. It is instantiated only under `I2C_SEQ_TIMEOUT_EN`.

## Test plan
- Write 0x50, reg 0x10, len 2, data 0xAA 0x55, all ACK → elements {01,0,A0} {00,0,10} {00,0,AA} {00,0,55} {11,…}; `done_o` once; no errors.
- Read 0x50, reg 0x00, len 3, rx 0x11 0x22 0x33 → elements {01,0,A0} {00,0,00} {10,0,A1}, receive ACK bits 0, 0, 1, then STOP; `rd_valid_o` ×3 with 0x11, 0x22, 0x33.
- Probe 0x3C, len 0, address NACK → {01,0,78}, then STOP; `err_nack_o`=1; `done_o`=1.
- `fsm_error_i` in the same cycle as `acknack_valid_i` during REG → `err_bus_o`=1; IDLE next cycle; no STOP; no `done_o`.
- With `I2C_SEQ_TIMEOUT_EN`, TIMEOUT_W=4, `txd_ready_i` held 0 → `err_timeout_o` after 15 stalled cycles; `txd_valid_o`=0; `cmd_ready_o`=1.
- `rst` asserted mid-WDATA → all outputs at reset values next cycle; a new command is accepted afterwards.
